// File: rtl/bday_pkg.sv
// Constants and types shared by the birthday-message display blocks
// (button_pager upstream, vga_driver downstream).
package bday_pkg;
    localparam int CLK_HZ    = 25_000_000;
    localparam int NUM_PAGES = 4;
    localparam int PAGE_W    = 2;

    typedef logic [PAGE_W-1:0] page_t;
endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus level debouncer. A new level is accepted only
// after the synchronised input has held it for DEBOUNCE_CYCLES cycles.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic level
);
    localparam int             CW   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta;
    logic          sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta  <= 1'b0;
            sync  <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            meta <= in;
            sync <= meta;
            // Any return to the accepted level restarts the count.
            if (sync == level) begin
                cnt <= '0;
            end else if (cnt == TERM) begin
                level <= sync;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/button_pager.sv
// Debounced push-button to message-page selector for the VGA stage.
// Optional feature: define LONG_PRESS_EN for hold-to-return-to-page-0.
module button_pager
    import bday_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int NUM_PAGES       = bday_pkg::NUM_PAGES,
    parameter int PAGE_W          = bday_pkg::PAGE_W,
    parameter int LONG_CYCLES     = 50000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              button,
    output logic              btn_level,
    output logic              btn_press,
    output logic [PAGE_W-1:0] page,
    output logic              page_change
);
    localparam logic [PAGE_W-1:0] LAST_PAGE = PAGE_W'(NUM_PAGES - 1);

    if (DEBOUNCE_CYCLES < 2 || NUM_PAGES < 2 || (1 << PAGE_W) < NUM_PAGES ||
        LONG_CYCLES < 2) begin : g_bad_cfg
        $error("button_pager: illegal parameter combination");
    end

    logic level_q;
    logic rise;
    logic long_fire;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk  (clk),
        .reset(reset),
        .in   (button),
        .level(btn_level)
    );

    assign rise = btn_level & ~level_q;

`ifdef LONG_PRESS_EN
    localparam int             HW        = $clog2(LONG_CYCLES);
    localparam logic [HW-1:0]  HOLD_TERM = HW'(LONG_CYCLES - 1);

    logic [HW-1:0] hold;
    logic          long_done;

    // long_done makes the return-to-0 fire once per hold after saturation.
    assign long_fire = (hold == HOLD_TERM) && !long_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold      <= '0;
            long_done <= 1'b0;
        end else if (!btn_level) begin
            hold      <= '0;
            long_done <= 1'b0;
        end else begin
            if (hold != HOLD_TERM)
                hold <= hold + HW'(1);
            if (long_fire)
                long_done <= 1'b1;
        end
    end
`else
    assign long_fire = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q     <= 1'b0;
            btn_press   <= 1'b0;
            page_change <= 1'b0;
            page        <= '0;
        end else begin
            level_q     <= btn_level;
            btn_press   <= rise;
            page_change <= rise | long_fire;
            if (rise)
                page <= (page == LAST_PAGE) ? '0 : page + PAGE_W'(1);
            else if (long_fire)
                page <= '0;
        end
    end
endmodule
